// File: rtl/axi_sram_slave_if.sv
// AXI3-style single-beat bus bundle between a master and the SRAM slave.
interface axi_sram_slave_if;
    // Read address channel
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    // Read data channel
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    // Write address channel
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    // Write data channel
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    // Write response channel
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wid, wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wid, wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// Single-beat AXI slave in front of a single-port word SRAM. Independent read
// and write FSMs share the memory port through a round-robin arbiter.
module axi_sram_slave #(
    parameter int MEM_AW = 10
) (
    input logic        aclk,
    input logic        areset,
    axi_sram_slave_if.slave bus
);
    localparam int         DEPTH       = 1 << MEM_AW;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    logic [31:0] mem [0:DEPTH-1];

    r_state_t          r_state, r_next;
    logic [3:0]        rid_q;
    logic [MEM_AW-1:0] r_idx;
    logic              r_legal;
    logic [31:0]       rdata_q;
    logic [1:0]        rresp_q;

    w_state_t          w_state, w_next;
    logic              aw_got, w_got;
    logic [3:0]        bid_q;
    logic [MEM_AW-1:0] w_idx;
    logic              w_legal;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [1:0]        bresp_q;

    logic last_grant_wr;
    logic rd_req, wr_req, rd_grant, wr_grant, rd_done, wr_done;
    logic arready, rvalid, awready, wready, bvalid;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

    // Only single-beat bursts of at most one word per beat are served.
    function automatic logic is_legal(input logic [7:0] len, input logic [2:0] size);
        return (len == 8'd0) && (size <= 3'd2);
    endfunction

    assign ar_hs = bus.arvalid & arready;
    assign r_hs  = rvalid & bus.rready;
    assign aw_hs = bus.awvalid & awready;
    assign w_hs  = bus.wvalid & wready;
    assign b_hs  = bvalid & bus.bready;

    // Memory port arbitration: on conflict the side not granted last wins.
    always_comb begin
        rd_req   = (r_state == R_WAIT) && r_legal;
        wr_req   = (w_state == W_WAIT) && w_legal;
        rd_grant = rd_req && (!wr_req || last_grant_wr);
        wr_grant = wr_req && !rd_grant;
        // Illegal requests complete without touching the memory port.
        rd_done  = (r_state == R_WAIT) && (!r_legal || rd_grant);
        wr_done  = (w_state == W_WAIT) && (!w_legal || wr_grant);
    end

    // Remember which side took the port last.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge aclk) begin
        if (areset)
            last_grant_wr <= 1'b0;
        else if (rd_grant || wr_grant)
            last_grant_wr <= wr_grant;
    end

    // ---------------- Read path ----------------

    // Read FSM state register.
    always_ff @(posedge aclk) begin
        if (areset) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    // Read FSM next-state logic.
    // NOTE: defaulting r_next before the case keeps this purely combinational;
    // any path leaving it unassigned would infer a latch.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)   r_next = R_WAIT;
            R_WAIT:  if (rd_done) r_next = R_RESP;
            R_RESP:  if (r_hs)    r_next = R_IDLE;
            default:              r_next = R_IDLE;
        endcase
    end

    // Read FSM outputs; ready is masked while reset is held.
    always_comb begin
        arready = (r_state == R_IDLE) && !areset;
        rvalid  = (r_state == R_RESP);
    end

    // Read request capture and response code.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rid_q   <= '0;
            r_idx   <= '0;
            r_legal <= 1'b0;
            rresp_q <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                rid_q   <= bus.arid;
                r_idx   <= bus.araddr[MEM_AW+1:2];
                r_legal <= is_legal(bus.arlen, bus.arsize);
            end
            if (rd_done)
                rresp_q <= r_legal ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Synchronous memory read into the held response data register.
    always_ff @(posedge aclk) begin
        if (areset)
            rdata_q <= '0;
        else if (rd_done)
            rdata_q <= r_legal ? mem[r_idx] : 32'h0;
    end

    // ---------------- Write path ----------------

    // Write FSM state register.
    always_ff @(posedge aclk) begin
        if (areset) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    // Write FSM next-state logic: AW and W may arrive in any order.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if ((aw_got || aw_hs) && (w_got || w_hs)) w_next = W_WAIT;
            W_WAIT:  if (wr_done) w_next = W_RESP;
            W_RESP:  if (b_hs)    w_next = W_IDLE;
            default:              w_next = W_IDLE;
        endcase
    end

    // Write FSM outputs; each channel is accepted once per transaction.
    always_comb begin
        awready = (w_state == W_IDLE) && !aw_got && !areset;
        wready  = (w_state == W_IDLE) && !w_got  && !areset;
        bvalid  = (w_state == W_RESP);
    end

    // Write request/data capture and response code.
    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            bid_q   <= '0;
            w_idx   <= '0;
            w_legal <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            if (b_hs) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end
            if (aw_hs) begin
                bid_q   <= bus.awid;
                w_idx   <= bus.awaddr[MEM_AW+1:2];
                w_legal <= is_legal(bus.awlen, bus.awsize);
            end
            if (w_hs) begin
                wdata_q <= bus.wdata;
                wstrb_q <= bus.wstrb;
            end
            if (wr_done)
                bresp_q <= w_legal ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Byte-lane memory write; a grant coinciding with reset is dropped.
    // NOTE: the array itself has no reset so contents survive areset and the
    // storage can map onto a RAM macro.
    always_ff @(posedge aclk) begin
        if (wr_grant && !areset) begin
            for (int i = 0; i < 4; i++)
                if (wstrb_q[i])
                    mem[w_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
    end

    // ---------------- Bus outputs ----------------
    assign bus.arready = arready;
    assign bus.rvalid  = rvalid;
    assign bus.rid     = rid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rlast   = 1'b1;
    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.bvalid  = bvalid;
    assign bus.bid     = bid_q;
    assign bus.bresp   = bresp_q;

    // Inputs the slave deliberately ignores (burst type, W id/last, aliased bits).
    logic unused_ok;
    assign unused_ok = ^{bus.arburst, bus.awburst, bus.wid, bus.wlast,
                         bus.araddr[31:MEM_AW+2], bus.araddr[1:0],
                         bus.awaddr[31:MEM_AW+2], bus.awaddr[1:0]};
endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: directed scenarios plus randomized concurrent
// traffic, checked every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_axi_sram_slave;
    localparam int MEM_AW = 10;
    localparam int DEPTH  = 1 << MEM_AW;

    logic aclk   = 1'b0;
    logic areset = 1'b1;

    axi_sram_slave_if bus();

    axi_sram_slave #(.MEM_AW(MEM_AW)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 aclk = ~aclk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: handshake never completed (t=%0t)", name, $time);
    endtask

    function automatic bit legal(input logic [7:0] len, input logic [2:0] size);
        return (len == 8'd0) && (size <= 3'd2);
    endfunction

    // ---------------- Reference model ----------------
    // Each side is either idle (0), holding a request for the port (1) or
    // presenting a response (2). Memory is a plain word array.
    logic [31:0]       m_mem [0:DEPTH-1];
    int                r_ph, w_ph;
    logic [3:0]        m_rid, m_bid;
    logic [MEM_AW-1:0] m_ridx, m_widx;
    bit                m_rlegal, m_wlegal, m_aw_got, m_w_got, m_last_wr;
    logic [31:0]       m_rdata, m_wdata;
    logic [3:0]        m_wstrb;
    logic [1:0]        m_rresp, m_bresp;

    initial for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    always @(posedge aclk) begin : model
        bit rq, wq, gr, gw;
        if (areset) begin
            r_ph = 0; w_ph = 0; m_aw_got = 0; m_w_got = 0; m_last_wr = 0;
            m_rid = '0; m_bid = '0; m_rdata = '0; m_rresp = '0; m_bresp = '0;
        end else begin
            rq = (r_ph == 1) && m_rlegal;
            wq = (w_ph == 1) && m_wlegal;
            gr = rq && (!wq || m_last_wr);
            gw = wq && !gr;
            if (gr || gw) m_last_wr = gw;

            if (r_ph == 0) begin
                if (bus.arvalid) begin
                    m_rid    = bus.arid;
                    m_ridx   = bus.araddr[MEM_AW+1:2];
                    m_rlegal = legal(bus.arlen, bus.arsize);
                    r_ph     = 1;
                end
            end else if (r_ph == 1) begin
                if (!m_rlegal || gr) begin
                    m_rdata = m_rlegal ? m_mem[m_ridx] : 32'h0;
                    m_rresp = m_rlegal ? 2'b00 : 2'b10;
                    r_ph    = 2;
                end
            end else if (bus.rready) begin
                r_ph = 0;
            end

            if (w_ph == 0) begin
                if (bus.awvalid && !m_aw_got) begin
                    m_bid    = bus.awid;
                    m_widx   = bus.awaddr[MEM_AW+1:2];
                    m_wlegal = legal(bus.awlen, bus.awsize);
                    m_aw_got = 1;
                end
                if (bus.wvalid && !m_w_got) begin
                    m_wdata = bus.wdata;
                    m_wstrb = bus.wstrb;
                    m_w_got = 1;
                end
                if (m_aw_got && m_w_got) w_ph = 1;
            end else if (w_ph == 1) begin
                if (!m_wlegal || gw) begin
                    if (gw)
                        for (int b = 0; b < 4; b++)
                            if (m_wstrb[b]) m_mem[m_widx][8*b +: 8] = m_wdata[8*b +: 8];
                    m_bresp = m_wlegal ? 2'b00 : 2'b10;
                    w_ph    = 2;
                end
            end else if (bus.bready) begin
                w_ph = 0; m_aw_got = 0; m_w_got = 0;
            end
        end

        #1;
        check("arready", bus.arready, (r_ph == 0) && !areset);
        check("awready", bus.awready, (w_ph == 0) && !m_aw_got && !areset);
        check("wready",  bus.wready,  (w_ph == 0) && !m_w_got && !areset);
        check("rvalid",  bus.rvalid,  r_ph == 2);
        check("bvalid",  bus.bvalid,  w_ph == 2);
        check("rlast",   bus.rlast,   1'b1);
        check("rid",     bus.rid,     m_rid);
        check("rdata",   bus.rdata,   m_rdata);
        check("rresp",   bus.rresp,   m_rresp);
        check("bid",     bus.bid,     m_bid);
        check("bresp",   bus.bresp,   m_bresp);
    end

    // ---------------- Stimulus tasks (called at a falling edge) ----------------
    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [3:0] id);
        int n = 0;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size;
        bus.arburst = 2'($urandom); bus.arvalid = 1'b1;
        while (!bus.arready && n < 100) begin @(negedge aclk); n++; end
        if (n >= 100) timeout("ar_handshake");
        @(negedge aclk);
        bus.arvalid = 1'b0;
    endtask

    task automatic get_r(input bit rnd, output logic [3:0] id,
                         output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        bit done = 0;
        id = '0; data = '0; resp = '0;
        while (!done && n < 200) begin
            bus.rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.rvalid && bus.rready) begin
                done = 1; id = bus.rid; data = bus.rdata; resp = bus.rresp;
            end else begin
                @(negedge aclk); n++;
            end
        end
        if (!done) timeout("r_handshake");
        @(negedge aclk);
        bus.rready = 1'b0;
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [3:0] id, input int dly);
        int n = 0;
        repeat (dly) @(negedge aclk);
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size;
        bus.awburst = 2'($urandom); bus.awvalid = 1'b1;
        while (!bus.awready && n < 100) begin @(negedge aclk); n++; end
        if (n >= 100) timeout("aw_handshake");
        @(negedge aclk);
        bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
        int n = 0;
        repeat (dly) @(negedge aclk);
        bus.wid = 4'($urandom); bus.wdata = data; bus.wstrb = strb;
        bus.wlast = 1'b1; bus.wvalid = 1'b1;
        while (!bus.wready && n < 100) begin @(negedge aclk); n++; end
        if (n >= 100) timeout("w_handshake");
        @(negedge aclk);
        bus.wvalid = 1'b0;
    endtask

    task automatic get_b(input bit rnd, output logic [3:0] id, output logic [1:0] resp);
        int n = 0;
        bit done = 0;
        id = '0; resp = '0;
        while (!done && n < 200) begin
            bus.bready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.bvalid && bus.bready) begin
                done = 1; id = bus.bid; resp = bus.bresp;
            end else begin
                @(negedge aclk); n++;
            end
        end
        if (!done) timeout("b_handshake");
        @(negedge aclk);
        bus.bready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [7:0] len, input logic [2:0] size, input logic [3:0] id,
                            input int aw_dly, input int w_dly, input bit rnd,
                            output logic [3:0] bid, output logic [1:0] bresp);
        fork
            send_aw(addr, len, size, id, aw_dly);
            send_w(data, strb, w_dly);
        join
        get_b(rnd, bid, bresp);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [3:0] id, input bit rnd, output logic [3:0] rid,
                           output logic [31:0] data, output logic [1:0] resp);
        send_ar(addr, len, size, id);
        get_r(rnd, rid, data, resp);
    endtask

    // Random address onto one of the first 16 words, with aliased upper/low bits.
    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom & 32'hFFFF_F003;
        return a | (32'($urandom_range(0, 15)) << 2);
    endfunction

    // ---------------- Main sequence ----------------
    initial begin
        logic [3:0]  id;
        logic [31:0] d, d0;
        logic [1:0]  resp;
        bit          b_seen;

        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arvalid = 0; bus.rready = 0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 0; bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 0;
        bus.wvalid = 0; bus.bready = 0;

        // Reset values
        repeat (3) @(negedge aclk);
        check("rst_arready", bus.arready, 0);
        check("rst_awready", bus.awready, 0);
        check("rst_wready",  bus.wready,  0);
        check("rst_rvalid",  bus.rvalid,  0);
        check("rst_bvalid",  bus.bvalid,  0);
        check("rst_rdata",   bus.rdata,   0);
        check("rst_rlast",   bus.rlast,   1);
        areset = 1'b0;
        #1;
        check("rel_arready", bus.arready, 1);
        check("rel_awready", bus.awready, 1);
        check("rel_wready",  bus.wready,  1);
        @(negedge aclk);

        // Give the first 16 words known contents
        for (int i = 0; i < 16; i++)
            do_write(32'(i * 4), $urandom, 4'hF, 8'd0, 3'd2, 4'(i), 0, 0, 0, id, resp);

        // Full-word write then readback
        do_write(32'h10, 32'hA5A5_A5A5, 4'hF, 8'd0, 3'd2, 4'd3, 0, 0, 0, id, resp);
        check("wr10_bid", id, 4'd3);
        check("wr10_bresp", resp, 2'b00);
        do_read(32'h10, 8'd0, 3'd2, 4'd7, 0, id, d, resp);
        check("rd10_data", d, 32'hA5A5_A5A5);
        check("rd10_rid", id, 4'd7);
        check("rd10_rresp", resp, 2'b00);

        // Byte-lane merge, read through an aliased address
        do_write(32'h20, 32'h1122_3344, 4'hF, 8'd0, 3'd2, 4'd1, 0, 0, 0, id, resp);
        do_write(32'h20, 32'hFFFF_FFFF, 4'b0101, 8'd0, 3'd2, 4'd1, 0, 0, 0, id, resp);
        do_read(32'hABCD_E023, 8'd0, 3'd2, 4'd2, 0, id, d, resp);
        check("merge_data", d, 32'h11FF_33FF);

        // W three cycles ahead of AW
        do_write(32'h24, 32'h0102_0304, 4'hF, 8'd0, 3'd2, 4'd5, 3, 0, 0, id, resp);
        check("wfirst_bid", id, 4'd5);
        check("wfirst_bresp", resp, 2'b00);

        // Illegal requests
        do_read(32'h20, 8'd3, 3'd2, 4'd4, 0, id, d, resp);
        check("ill_rd_resp", resp, 2'b10);
        check("ill_rd_data", d, 32'h0);
        do_write(32'h20, 32'h0, 4'hF, 8'd0, 3'd3, 4'd6, 0, 0, 0, id, resp);
        check("ill_wr_resp", resp, 2'b10);
        do_read(32'h20, 8'd0, 3'd2, 4'd4, 0, id, d, resp);
        check("ill_wr_untouched", d, 32'h11FF_33FF);

        // Reset while the write waits for its grant
        bus.awid = 4'd9; bus.awaddr = 32'h10; bus.awlen = 0; bus.awsize = 3'd2; bus.awvalid = 1;
        bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF; bus.wvalid = 1;
        @(negedge aclk);
        bus.awvalid = 0; bus.wvalid = 0; areset = 1'b1;
        @(negedge aclk);
        check("rstw_bvalid", bus.bvalid, 0);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        check("rstw_arready", bus.arready, 1);
        check("rstw_awready", bus.awready, 1);
        check("rstw_wready",  bus.wready,  1);
        @(negedge aclk);
        do_read(32'h10, 8'd0, 3'd2, 4'd1, 0, id, d, resp);
        check("rstw_untouched", d, 32'hA5A5_A5A5);

        // Conflict after the lone read above: the write wins, read sees new data
        fork
            do_write(32'h30, 32'h0BAD_F00D, 4'hF, 8'd0, 3'd2, 4'd1, 0, 0, 0, id, resp);
            begin
                logic [3:0] rid2; logic [1:0] rr2;
                do_read(32'h30, 8'd0, 3'd2, 4'd2, 0, rid2, d, rr2);
            end
        join
        check("conf1_rdata", d, 32'h0BAD_F00D);

        // After a lone write, the next conflict goes to the read (old data)
        do_write(32'h30, 32'h1234_5678, 4'hF, 8'd0, 3'd2, 4'd1, 0, 0, 0, id, resp);
        b_seen = 0;
        fork
            begin
                do_write(32'h30, 32'hCAFE_BABE, 4'hF, 8'd0, 3'd2, 4'd8, 0, 0, 0, id, resp);
                b_seen = 1;
            end
            begin
                logic [3:0] rid2; logic [1:0] rr2;
                send_ar(32'h30, 8'd0, 3'd2, 4'd2);
                @(negedge aclk);
                d0 = bus.rdata;
                check("conf2_rdata", d0, 32'h1234_5678);
                repeat (10) begin
                    @(negedge aclk);
                    check("stall_rvalid", bus.rvalid, 1);
                    check("stall_rdata", bus.rdata, d0);
                end
                check("stall_write_done", b_seen, 1);
                get_r(0, rid2, d, rr2);
            end
        join
        do_read(32'h30, 8'd0, 3'd2, 4'd3, 0, id, d, resp);
        check("conf2_final", d, 32'hCAFE_BABE);

        // Randomized concurrent traffic with back-pressure
        fork
            for (int i = 0; i < 120; i++) begin
                logic [3:0] rid_r; logic [31:0] rd_r; logic [1:0] rr_r;
                logic [7:0] len; logic [2:0] size;
                repeat ($urandom_range(0, 3)) @(negedge aclk);
                len  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
                size = 3'($urandom_range(0, 3));
                do_read(rand_addr(), len, size, 4'($urandom), 1, rid_r, rd_r, rr_r);
            end
            for (int i = 0; i < 120; i++) begin
                logic [3:0] bid_w; logic [1:0] br_w;
                logic [7:0] len; logic [2:0] size;
                repeat ($urandom_range(0, 3)) @(negedge aclk);
                len  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
                size = 3'($urandom_range(0, 3));
                do_write(rand_addr(), $urandom, 4'($urandom), len, size, 4'($urandom),
                         $urandom_range(0, 3), $urandom_range(0, 3), 1, bid_w, br_w);
            end
        join

        repeat (3) @(negedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
